tri_proj_seq: RTL and testbench

Sequencer that feeds the single-vertex projection unit one triangle at a time. It accepts a world-space triangle of three float vertices, issues each vertex in turn to the projection unit, and collects the three 9-bit screen-space results. It then performs back-face/degenerate culling on the projected triangle and hands surviving triangles to the rasterizer with a valid/ready handshake. It sits between the object/vertex fetch stage and the rasterizer, and owns the projection unit's input port exclusively.

---
 rtl/tri_proj_seq_if.sv | 37 +++
 rtl/tri_proj_seq.sv | 131 +++++++++++++
 tb/tb_tri_proj_seq.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tri_proj_seq_if.sv
// Bus bundle around tri_proj_seq: triangle input from vertex fetch, the
// projection unit port, and the triangle output to the rasterizer.
// slave = the sequencer's view, master = the surrounding environment's view.
interface tri_proj_seq_if;
  logic [3:0][31:0] v0_in, v1_in, v2_in;
  logic             tri_valid_in;
  logic             obj_done_in;
  logic             tri_ready_out;
  logic [3:0][31:0] proj_coor_out;
  logic             proj_valid_out;
  logic             proj_obj_done_out;
  logic             proj_ready_in;
  logic [2:0][8:0]  proj_coor_in;
  logic             proj_valid_in;
  logic [2:0][8:0]  v0_out, v1_out, v2_out;
  logic             tri_valid_out;
  logic             tri_ready_in;
  logic             obj_done_out;
  logic [15:0]      cull_count_out;
  logic             err_timeout_out;

  modport slave (
    input  v0_in, v1_in, v2_in, tri_valid_in, obj_done_in,
           proj_ready_in, proj_coor_in, proj_valid_in, tri_ready_in,
    output tri_ready_out, proj_coor_out, proj_valid_out, proj_obj_done_out,
           v0_out, v1_out, v2_out, tri_valid_out, obj_done_out,
           cull_count_out, err_timeout_out
  );

  modport master (
    output v0_in, v1_in, v2_in, tri_valid_in, obj_done_in,
           proj_ready_in, proj_coor_in, proj_valid_in, tri_ready_in,
    input  tri_ready_out, proj_coor_out, proj_valid_out, proj_obj_done_out,
           v0_out, v1_out, v2_out, tri_valid_out, obj_done_out,
           cull_count_out, err_timeout_out
  );
endinterface

// File: rtl/tri_proj_seq.sv
// Triangle sequencer: feeds three vertices one by one through the shared
// projection unit, culls back-facing / zero-area results and hands the
// survivors to the rasterizer. All outputs are registered.
module tri_proj_seq #(
  parameter int PROJ_TIMEOUT  = 1023,
  parameter bit CULL_BACKFACE = 1'b1
) (
  input logic           clk_in,
  input logic           rst_in,
  tri_proj_seq_if.slave bus
);
  localparam int TW = (PROJ_TIMEOUT < 2) ? 1 : $clog2(PROJ_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CULL, OUT} state_t;

  state_t                state, state_nx;
  logic [2:0][3:0][31:0] vtx;      // latched world-space vertices, [vc]
  logic [2:0][2:0][8:0]  res;      // projected results, [vc]
  logic [1:0]            vc;
  logic [TW-1:0]         tcnt;
  logic                  obj_q;
  logic                  take, issue, got, tmo, culled;
  logic signed [9:0]     dx1, dy1, dx2, dy2;
  logic signed [19:0]    p_a, p_b;
  logic signed [20:0]    area;

  // object completion is handled here, never forwarded to the projection unit
  assign bus.proj_obj_done_out = 1'b0;

  // signed area of the projected triangle at full width (no truncation)
  always_comb begin
    dx1  = $signed({1'b0, res[1][2]}) - $signed({1'b0, res[0][2]});
    dy1  = $signed({1'b0, res[1][1]}) - $signed({1'b0, res[0][1]});
    dx2  = $signed({1'b0, res[2][2]}) - $signed({1'b0, res[0][2]});
    dy2  = $signed({1'b0, res[2][1]}) - $signed({1'b0, res[0][1]});
    p_a  = dx1 * dy2;
    p_b  = dx2 * dy1;
    area = {p_a[19], p_a} - {p_b[19], p_b};
    culled = (area == '0) || (CULL_BACKFACE && area[20]);
  end

  // next-state and per-cycle strobes
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    issue    = 1'b0;
    got      = 1'b0;
    tmo      = 1'b0;
    case (state)
      IDLE:  if (bus.tri_valid_in) begin
               take     = 1'b1;
               state_nx = ISSUE;
             end
      ISSUE: if (bus.proj_ready_in) begin
               issue    = 1'b1;
               state_nx = WAIT;
             end
      // a result arriving on the timeout cycle still counts
      WAIT:  if (bus.proj_valid_in) begin
               got      = 1'b1;
               state_nx = (vc == 2'd2) ? CULL : ISSUE;
             end else if (tcnt == TW'(PROJ_TIMEOUT - 1)) begin
               tmo      = 1'b1;
               state_nx = IDLE;
             end
      CULL:  state_nx = culled ? IDLE : OUT;
      OUT:   if (bus.tri_ready_in) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  // datapath and registered outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vtx                 <= '0;
      res                 <= '0;
      vc                  <= '0;
      tcnt                <= '0;
      obj_q               <= 1'b0;
      bus.tri_ready_out   <= 1'b1;
      bus.proj_coor_out   <= '0;
      bus.proj_valid_out  <= 1'b0;
      bus.v0_out          <= '0;
      bus.v1_out          <= '0;
      bus.v2_out          <= '0;
      bus.tri_valid_out   <= 1'b0;
      bus.obj_done_out    <= 1'b0;
      bus.cull_count_out  <= '0;
      bus.err_timeout_out <= 1'b0;
    end else begin
      bus.tri_ready_out  <= (state_nx == IDLE);
      bus.proj_valid_out <= issue;
      bus.tri_valid_out  <= (state_nx == OUT);
      // sideband while a triangle is presented, lone pulse when it dies
      bus.obj_done_out   <= obj_q && ((state_nx == OUT) || tmo ||
                                      (state == CULL && culled));
      if (take) begin
        vtx               <= {bus.v2_in, bus.v1_in, bus.v0_in};
        obj_q             <= bus.obj_done_in;
        vc                <= 2'd0;
        bus.proj_coor_out <= bus.v0_in;
      end
      if (issue) tcnt <= '0;
      else if (state == WAIT && !got && !tmo) tcnt <= tcnt + 1'b1;
      if (got) begin
        res[vc] <= bus.proj_coor_in;
        if (vc != 2'd2) begin
          vc                <= vc + 2'd1;
          bus.proj_coor_out <= vtx[vc + 2'd1];
        end
      end
      if (tmo) bus.err_timeout_out <= 1'b1;
      if (state == CULL) begin
        if (culled) begin
          if (bus.cull_count_out != 16'hFFFF)
            bus.cull_count_out <= bus.cull_count_out + 16'd1;
        end else begin
          bus.v0_out <= res[0];
          bus.v1_out <= res[1];
          bus.v2_out <= res[2];
        end
      end
    end
  end
endmodule

// File: tb/tb_tri_proj_seq.sv
// Bench for tri_proj_seq: stub projection unit with fixed latency, a
// queue of expected output events, and a monitor that pops and compares.
module tb_tri_proj_seq;
  localparam int L   = 20;
  localparam int TMO = 50;

  typedef logic [3:0][31:0] vtx_t;
  typedef logic [2:0][8:0]  pt_t;
  typedef struct { bit lone; pt_t a, b, c; bit od; } exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  tri_proj_seq_if b0 ();
  tri_proj_seq_if b1 ();

  tri_proj_seq #(.PROJ_TIMEOUT(TMO), .CULL_BACKFACE(1'b1)) dut0 (
    .clk_in(clk_in), .rst_in(rst_in), .bus(b0.slave));
  tri_proj_seq #(.PROJ_TIMEOUT(TMO), .CULL_BACKFACE(1'b0)) dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .bus(b1.slave));

  bit         sel = 1'b0;
  logic       tv = 1'b0, od = 1'b0;
  vtx_t       iv0 = '0, iv1 = '0, iv2 = '0;
  logic       pv = 1'b0, pr = 1'b1;
  pt_t        pc = '0;
  logic [1:0] rdy_mode = 2'd1;
  logic       rnd_bit = 1'b0;
  logic       rdy;
  bit         mute = 1'b0;

  assign rdy = (rdy_mode == 2'd2) ? rnd_bit : rdy_mode[0];

  assign b0.tri_valid_in = tv & ~sel;
  assign b1.tri_valid_in = tv & sel;
  assign b0.v0_in = iv0;  assign b1.v0_in = iv0;
  assign b0.v1_in = iv1;  assign b1.v1_in = iv1;
  assign b0.v2_in = iv2;  assign b1.v2_in = iv2;
  assign b0.obj_done_in   = od;  assign b1.obj_done_in   = od;
  assign b0.proj_ready_in = pr;  assign b1.proj_ready_in = pr;
  assign b0.proj_coor_in  = pc;  assign b1.proj_coor_in  = pc;
  assign b0.proj_valid_in = pv;  assign b1.proj_valid_in = pv;
  assign b0.tri_ready_in  = rdy; assign b1.tri_ready_in  = rdy;

  logic s_tro, s_pvo, s_tvo, s_odo, s_err, s_pod;
  vtx_t s_pco;
  pt_t  s_v0, s_v1, s_v2;
  logic [15:0] s_cc;

  always_comb begin
    if (sel) begin
      s_tro = b1.tri_ready_out; s_pvo = b1.proj_valid_out; s_tvo = b1.tri_valid_out;
      s_odo = b1.obj_done_out;  s_err = b1.err_timeout_out; s_pod = b1.proj_obj_done_out;
      s_pco = b1.proj_coor_out; s_v0 = b1.v0_out; s_v1 = b1.v1_out; s_v2 = b1.v2_out;
      s_cc  = b1.cull_count_out;
    end else begin
      s_tro = b0.tri_ready_out; s_pvo = b0.proj_valid_out; s_tvo = b0.tri_valid_out;
      s_odo = b0.obj_done_out;  s_err = b0.err_timeout_out; s_pod = b0.proj_obj_done_out;
      s_pco = b0.proj_coor_out; s_v0 = b0.v0_out; s_v1 = b0.v1_out; s_v2 = b0.v2_out;
      s_cc  = b0.cull_count_out;
    end
  end

  int   n_cmp = 0, n_bad = 0;
  vtx_t iq[$];
  pt_t  rq[$];
  exp_t exq[$];
  int   n_iss = 0;
  int   cull_m [2];
  bit   err_m [2];

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic pt_t pt(input int x, input int y, input int z);
    return {9'(x), 9'(y), 9'(z)};
  endfunction

  function automatic vtx_t rv();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // signed area straight from the geometry, plain integer arithmetic
  function automatic int area(input pt_t a, input pt_t b, input pt_t c);
    return (int'(b[2]) - int'(a[2])) * (int'(c[1]) - int'(a[1])) -
           (int'(c[2]) - int'(a[2])) * (int'(b[1]) - int'(a[1]));
  endfunction

  always @(negedge clk_in) rnd_bit = 1'($urandom_range(0, 1));

  // projection unit stub: fixed latency, checks the vertex it is handed
  int cnt = 0;
  always @(negedge clk_in) begin
    pv = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0 && !mute) begin
        pv = 1'b1;
        if (rq.size() > 0) pc = rq.pop_front();
        else               pc = '0;
      end
    end
    if (!rst_in && s_pvo) begin
      n_iss++;
      if (iq.size() == 0) chk("unexpected_issue", s_pvo, 1'b0);
      else                chk("proj_coor_out", s_pco, iq.pop_front());
      cnt = L;
    end
    pr = (cnt == 0);
  end

  // output monitor
  logic prev_tvo = 1'b0;
  pt_t  h0, h1, h2;
  logic hod;
  exp_t me;
  always @(negedge clk_in) begin
    if (rst_in) prev_tvo = 1'b0;
    else begin
      if (s_tvo) begin
        if (!prev_tvo) begin
          if (exq.size() == 0) chk("unexpected_tri", s_tvo, 1'b0);
          else begin
            me = exq.pop_front();
            chk("tri_kind", s_tvo, !me.lone);
            chk("tri_v0", s_v0, me.a);
            chk("tri_v1", s_v1, me.b);
            chk("tri_v2", s_v2, me.c);
            chk("tri_obj_done", s_odo, me.od);
          end
          h0 = s_v0; h1 = s_v1; h2 = s_v2; hod = s_odo;
        end else
          chk("hold_stable", {s_v0, s_v1, s_v2, s_odo}, {h0, h1, h2, hod});
      end else if (s_odo) begin
        if (exq.size() == 0) chk("unexpected_done", s_odo, 1'b0);
        else begin
          me = exq.pop_front();
          chk("done_kind", s_tvo, !me.lone);
        end
      end
      chk("proj_obj_done", s_pod, 1'b0);
      prev_tvo = s_tvo;
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (!s_tro && k < 3000) begin
      @(negedge clk_in);
      k++;
    end
    chk("ready_wait", s_tro, 1'b1);
  endtask

  task automatic send(input vtx_t a, input vtx_t b, input vtx_t c,
                      input pt_t r0, input pt_t r1, input pt_t r2,
                      input bit o, input bit m, input bit stall);
    int   base, ar, s, k;
    bit   cb, err0;
    exp_t e;
    s  = int'(sel);
    cb = (sel == 1'b0);
    wait_idle();
    base = n_iss;
    err0 = err_m[s];
    mute = m;
    iq.push_back(a); iq.push_back(b); iq.push_back(c);
    if (!m) begin rq.push_back(r0); rq.push_back(r1); rq.push_back(r2); end
    e.lone = 1'b1; e.a = r0; e.b = r1; e.c = r2; e.od = o;
    if (m) begin
      err_m[s] = 1'b1;
      if (o) exq.push_back(e);
    end else begin
      ar = area(r0, r1, r2);
      if (ar == 0 || (cb && ar < 0)) begin
        if (cull_m[s] < 65535) cull_m[s]++;
        if (o) exq.push_back(e);
      end else begin
        e.lone = 1'b0;
        exq.push_back(e);
      end
    end
    if (stall) rdy_mode = 2'd0;
    iv0 = a; iv1 = b; iv2 = c; od = o; tv = 1'b1;
    @(negedge clk_in);
    tv = 1'b0;
    chk("ready_drop", s_tro, 1'b0);
    chk("issue_early", s_pvo, 1'b0);
    @(negedge clk_in);
    chk("first_issue", s_pvo, 1'b1);
    if (m) begin
      repeat (TMO - 1) @(negedge clk_in);
      chk("err_early", s_err, err0);
      @(negedge clk_in);
      chk("err_set", s_err, 1'b1);
      chk("ready_after_tmo", s_tro, 1'b1);
      iq.delete();
    end
    if (stall) begin
      k = 0;
      while (!s_tvo && k < 500) begin @(negedge clk_in); k++; end
      chk("stall_valid", s_tvo, 1'b1);
      for (int i = 0; i < 30; i++) begin
        tv = (i >= 5 && i < 10);
        @(negedge clk_in);
        chk("stall_busy", {s_tvo, s_tro}, 2'b10);
      end
      tv = 1'b0;
      rdy_mode = 2'd1;
      @(negedge clk_in);
      chk("accept_first", {s_tvo, s_tro}, 2'b01);
    end
    wait_idle();
    @(negedge clk_in);
    chk("issues", n_iss - base, m ? 1 : 3);
    chk("cull_count", s_cc, cull_m[s]);
    chk("err_sticky", s_err, err_m[s]);
    mute = 1'b0;
  endtask

  initial begin
    #800000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int base, k;
    pt_t p0, p1, p2;
    cull_m[0] = 0; cull_m[1] = 0; err_m[0] = 1'b0; err_m[1] = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_ready", s_tro, 1'b1);
    chk("rst_flags", {s_pvo, s_tvo, s_odo, s_err}, 4'b0);
    chk("rst_cull", s_cc, 16'd0);
    chk("rst_coor", s_pco, '0);
    chk("rst_vout", {s_v0, s_v1, s_v2}, '0);
    rst_in = 1'b0;
    @(negedge clk_in);

    send(rv(), rv(), rv(), pt(10, 10, 5), pt(100, 10, 6), pt(10, 100, 7), 1'b0, 1'b0, 1'b0);
    send(rv(), rv(), rv(), pt(10, 10, 1), pt(10, 100, 2), pt(100, 10, 3), 1'b1, 1'b0, 1'b0);
    send(rv(), rv(), rv(), pt(0, 0, 1), pt(5, 5, 2), pt(10, 10, 3), 1'b1, 1'b0, 1'b0);
    send(rv(), rv(), rv(), pt(0, 0, 9), pt(511, 0, 8), pt(0, 511, 7), 1'b1, 1'b0, 1'b0);
    send(rv(), rv(), rv(), pt(0, 511, 0), pt(511, 0, 0), pt(0, 0, 0), 1'b0, 1'b0, 1'b0);
    send(rv(), rv(), rv(), '0, '0, '0, 1'b1, 1'b1, 1'b0);
    send(rv(), rv(), rv(), pt(20, 30, 1), pt(300, 40, 2), pt(50, 400, 3), 1'b1, 1'b0, 1'b0);
    send(rv(), rv(), rv(), pt(10, 10, 5), pt(100, 10, 6), pt(10, 100, 7), 1'b1, 1'b0, 1'b1);

    rdy_mode = 2'd2;
    for (int i = 0; i < 25; i++) begin
      p0 = pt($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511));
      p1 = pt($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511));
      p2 = pt($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511));
      if ($urandom_range(0, 3) == 0) p2 = p1;
      send(rv(), rv(), rv(), p0, p1, p2, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    rdy_mode = 2'd1;

    // reset while waiting on vertex 1's projection
    wait_idle();
    base = n_iss;
    iv0 = rv(); iv1 = rv(); iv2 = rv();
    iq.push_back(iv0); iq.push_back(iv1); iq.push_back(iv2);
    rq.push_back(pt(1, 2, 3)); rq.push_back(pt(200, 2, 3)); rq.push_back(pt(1, 200, 3));
    od = 1'b1; tv = 1'b1;
    @(negedge clk_in);
    tv = 1'b0;
    k = 0;
    while (n_iss < base + 2 && k < 500) begin @(negedge clk_in); k++; end
    chk("reached_vertex1", n_iss - base, 2);
    repeat (3) @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    chk("arst_ready", s_tro, 1'b1);
    chk("arst_flags", {s_pvo, s_tvo, s_odo, s_err}, 4'b0);
    chk("arst_cull", s_cc, 16'd0);
    chk("arst_coor", s_pco, '0);
    chk("arst_vout", {s_v0, s_v1, s_v2}, '0);
    iq.delete(); rq.delete();
    cull_m[0] = 0; err_m[0] = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (25) @(negedge clk_in);
    chk("post_rst_idle", {s_tro, s_tvo, s_odo}, 3'b100);
    chk("post_rst_issues", n_iss - base, 2);
    send(rv(), rv(), rv(), pt(10, 10, 5), pt(10, 100, 6), pt(100, 10, 7), 1'b1, 1'b0, 1'b0);
    send(rv(), rv(), rv(), pt(7, 8, 5), pt(300, 9, 6), pt(40, 260, 7), 1'b0, 1'b0, 1'b0);

    // back-face culling disabled: negative area goes through, zero area does not
    sel = 1'b1;
    @(negedge clk_in);
    send(rv(), rv(), rv(), pt(10, 10, 5), pt(10, 100, 6), pt(100, 10, 7), 1'b0, 1'b0, 1'b0);
    send(rv(), rv(), rv(), pt(0, 0, 1), pt(5, 5, 2), pt(10, 10, 3), 1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk_in);
    chk("scoreboard_empty", exq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
